fetch_stage: RTL and testbench

// Instruction-fetch front end for the pipelined WISC core; sits upstream of decode.

---
 rtl/wisc_pkg.sv | 15 +
 rtl/fetch_stage_dff.sv | 17 +
 rtl/fetch_stage.sv | 131 +++++++++++++
 tb/tb_fetch_stage.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/wisc_pkg.sv
// Shared definitions for the WISC core front end: fetch state encoding and opcodes.
package wisc_pkg;

    typedef enum logic [2:0] {
        ST_START,
        ST_FETCH,
        ST_HOLD,
        ST_SQUASH,
        ST_HALTED
    } fetch_state_e;

    localparam logic [4:0] OP_HALT = 5'b00000;
    localparam logic [4:0] OP_NOP  = 5'b00001;

endpackage

// File: rtl/fetch_stage_dff.sv
// Plain D register with asynchronous active-low reset to a parameterised value.
module fetch_stage_dff #(
    parameter int unsigned   W       = 1,
    parameter logic [W-1:0]  RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q <= RST_VAL;
        else        q <= d;
    end

endmodule

// File: rtl/fetch_stage.sv
// WISC instruction-fetch stage: owns the PC, drives a variable-latency handshaked
// instruction memory and hands {instr, pc, pc+2} to decode through a one-entry buffer.
module fetch_stage
    import wisc_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 16,
    parameter int unsigned       INSTR_W  = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_rdy,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               ifid_valid,
    input  logic               ifid_ready,
    output logic [INSTR_W-1:0] ifid_instr,
    output logic [ADDR_W-1:0]  ifid_pc,
    output logic [ADDR_W-1:0]  ifid_pc2,
    output logic               halted,
    output logic               err
);

    localparam logic [ADDR_W-1:0] PC_STEP   = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] RESET_PC2 = RESET_PC + PC_STEP;

    fetch_state_e       state_q, state_d;
    logic               imem_req_q, halted_q, err_q, err_d;
    logic [ADDR_W-1:0]  pc_q, pc_d, req_addr_q, req_addr_d;
    logic               vld_q, vld_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0]  bpc_q, bpc_d, bpc2_q, bpc2_d;
    logic [ADDR_W-1:0]  pc_plus2;
    logic               buf_is_halt;

    assign pc_plus2    = pc_q + PC_STEP;
    assign buf_is_halt = (instr_q[INSTR_W-1 -: 5] == OP_HALT);
    assign err_d       = (imem_rdy && !imem_req_q) || (redirect && redirect_pc[0]);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        vld_d      = vld_q;
        instr_d    = instr_q;
        bpc_d      = bpc_q;
        bpc2_d     = bpc2_q;
        if (redirect) begin
            pc_d  = redirect_pc;
            vld_d = 1'b0;
            // An in-flight request must still be completed; only its data is discarded.
            if ((state_q == ST_FETCH || state_q == ST_SQUASH) && !imem_rdy) begin
                state_d = ST_SQUASH;
            end else begin
                state_d    = ST_FETCH;
                req_addr_d = redirect_pc;
            end
        end else begin
            case (state_q)
                ST_START: begin
                    state_d    = ST_FETCH;
                    req_addr_d = pc_q;
                end
                // FETCH is only entered with an empty buffer, so a fetched HALT always parks in HOLD.
                ST_FETCH: begin
                    if (imem_rdy) begin
                        vld_d   = 1'b1;
                        instr_d = imem_rdata;
                        bpc_d   = req_addr_q;
                        bpc2_d  = pc_plus2;
                        pc_d    = pc_plus2;
                        state_d = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (ifid_ready) begin
                        vld_d = 1'b0;
                        if (buf_is_halt) begin
                            state_d = ST_HALTED;
                        end else begin
                            state_d    = ST_FETCH;
                            req_addr_d = pc_q;
                        end
                    end
                end
                ST_SQUASH: begin
                    if (imem_rdy) begin
                        state_d    = ST_FETCH;
                        req_addr_d = pc_q;
                    end
                end
                ST_HALTED: state_d = ST_HALTED;
                default:   state_d = ST_START;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_START;
            imem_req_q <= 1'b0;
            halted_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            imem_req_q <= (state_d == ST_FETCH) || (state_d == ST_SQUASH);
            halted_q   <= (state_d == ST_HALTED);
            err_q      <= err_d;
        end
    end

    fetch_stage_dff #(.W(ADDR_W),  .RST_VAL(RESET_PC))  u_pc       (.clk(clk), .rst_n(rst_n), .d(pc_d),       .q(pc_q));
    fetch_stage_dff #(.W(ADDR_W),  .RST_VAL('0))        u_req_addr (.clk(clk), .rst_n(rst_n), .d(req_addr_d), .q(req_addr_q));
    fetch_stage_dff #(.W(1),       .RST_VAL(1'b0))      u_buf_vld  (.clk(clk), .rst_n(rst_n), .d(vld_d),      .q(vld_q));
    fetch_stage_dff #(.W(INSTR_W), .RST_VAL('0))        u_buf_ins  (.clk(clk), .rst_n(rst_n), .d(instr_d),    .q(instr_q));
    fetch_stage_dff #(.W(ADDR_W),  .RST_VAL(RESET_PC))  u_buf_pc   (.clk(clk), .rst_n(rst_n), .d(bpc_d),      .q(bpc_q));
    fetch_stage_dff #(.W(ADDR_W),  .RST_VAL(RESET_PC2)) u_buf_pc2  (.clk(clk), .rst_n(rst_n), .d(bpc2_d),     .q(bpc2_q));

    assign imem_req   = imem_req_q;
    assign imem_addr  = req_addr_q;
    assign ifid_valid = vld_q;
    assign ifid_instr = instr_q;
    assign ifid_pc    = bpc_q;
    assign ifid_pc2   = bpc2_q;
    assign halted     = halted_q;
    assign err        = err_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed, table-driven bench for fetch_stage with hand-written halt and async-reset sequences.
module tb_fetch_stage;
    import wisc_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_rdy;
    logic [15:0] imem_rdata;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        ifid_valid;
    logic        ifid_ready;
    logic [15:0] ifid_instr;
    logic [15:0] ifid_pc;
    logic [15:0] ifid_pc2;
    logic        halted;
    logic        err;

    int checks = 0;
    int errors = 0;

    localparam logic [15:0] I_NOP = {OP_NOP, 11'h011};

    // ctl = {redirect, imem_rdy, ifid_ready}; flg = {imem_req, ifid_valid, halted, err}
    typedef struct {
        logic [2:0]  ctl;
        logic [15:0] rpc;
        logic [15:0] rdata;
        logic [3:0]  flg;
        logic [15:0] addr;
        logic [15:0] ipc;
        logic [15:0] ipc2;
        logic [15:0] instr;
    } vec_t;

    vec_t vq[$];

    fetch_stage dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdy(imem_rdy), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .ifid_valid(ifid_valid), .ifid_ready(ifid_ready), .ifid_instr(ifid_instr),
        .ifid_pc(ifid_pc), .ifid_pc2(ifid_pc2), .halted(halted), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [3:0] flg, input logic [15:0] addr,
                              input logic [15:0] ipc, input logic [15:0] ipc2, input logic [15:0] instr);
        chk({tag, " imem_req"},   16'(imem_req),   16'(flg[3]));
        chk({tag, " ifid_valid"}, 16'(ifid_valid), 16'(flg[2]));
        chk({tag, " halted"},     16'(halted),     16'(flg[1]));
        chk({tag, " err"},        16'(err),        16'(flg[0]));
        chk({tag, " imem_addr"},  imem_addr,       addr);
        chk({tag, " ifid_pc"},    ifid_pc,         ipc);
        chk({tag, " ifid_pc2"},   ifid_pc2,        ipc2);
        chk({tag, " ifid_instr"}, ifid_instr,      instr);
    endtask

    task automatic add(input logic [2:0] ctl, input logic [15:0] rpc, input logic [15:0] rdata,
                       input logic [3:0] flg, input logic [15:0] addr, input logic [15:0] ipc,
                       input logic [15:0] ipc2, input logic [15:0] instr);
        vec_t v;
        v.ctl = ctl; v.rpc = rpc; v.rdata = rdata; v.flg = flg;
        v.addr = addr; v.ipc = ipc; v.ipc2 = ipc2; v.instr = instr;
        vq.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        redirect = 1'b0; redirect_pc = 16'h0; imem_rdy = 1'b0; imem_rdata = 16'h0; ifid_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();

        // Sequential fetch 0,2,4 with a 3-cycle memory stall at 4 and decode back-pressure.
        add(3'b000, 16'h0000, 16'h0000, 4'b1000, 16'h0000, 16'h0000, 16'h0002, 16'h0000);
        add(3'b010, 16'h0000, I_NOP,    4'b0100, 16'h0000, 16'h0000, 16'h0002, I_NOP);
        add(3'b001, 16'h0000, 16'h0000, 4'b1000, 16'h0002, 16'h0000, 16'h0002, I_NOP);
        add(3'b010, 16'h0000, 16'h0822, 4'b0100, 16'h0002, 16'h0002, 16'h0004, 16'h0822);
        add(3'b001, 16'h0000, 16'h0000, 4'b1000, 16'h0004, 16'h0002, 16'h0004, 16'h0822);
        for (int i = 0; i < 3; i++)
            add(3'b000, 16'h0000, 16'h0000, 4'b1000, 16'h0004, 16'h0002, 16'h0004, 16'h0822);
        add(3'b010, 16'h0000, 16'h0833, 4'b0100, 16'h0004, 16'h0004, 16'h0006, 16'h0833);
        for (int i = 0; i < 4; i++)
            add(3'b000, 16'h0000, 16'h0000, 4'b0100, 16'h0004, 16'h0004, 16'h0006, 16'h0833);
        add(3'b001, 16'h0000, 16'h0000, 4'b1000, 16'h0006, 16'h0004, 16'h0006, 16'h0833);
        // Redirect to 0x40 while 0x06 is outstanding: squash keeps 0x06, drops its data.
        add(3'b100, 16'h0040, 16'h0000, 4'b1000, 16'h0006, 16'h0004, 16'h0006, 16'h0833);
        add(3'b000, 16'h0000, 16'h0000, 4'b1000, 16'h0006, 16'h0004, 16'h0006, 16'h0833);
        add(3'b010, 16'h0000, 16'hDEAD, 4'b1000, 16'h0040, 16'h0004, 16'h0006, 16'h0833);
        add(3'b010, 16'h0000, 16'h4440, 4'b0100, 16'h0040, 16'h0040, 16'h0042, 16'h4440);
        // Redirect together with imem_rdy, then together with ifid_ready.
        add(3'b001, 16'h0000, 16'h0000, 4'b1000, 16'h0042, 16'h0040, 16'h0042, 16'h4440);
        add(3'b110, 16'h0080, 16'hBAD1, 4'b1000, 16'h0080, 16'h0040, 16'h0042, 16'h4440);
        add(3'b010, 16'h0000, 16'h5551, 4'b0100, 16'h0080, 16'h0080, 16'h0082, 16'h5551);
        add(3'b101, 16'h0100, 16'h0000, 4'b1000, 16'h0100, 16'h0080, 16'h0082, 16'h5551);
        add(3'b010, 16'h0000, 16'h6662, 4'b0100, 16'h0100, 16'h0100, 16'h0102, 16'h6662);
        // Odd redirect target pulses err and is used as-is.
        add(3'b100, 16'h0201, 16'h0000, 4'b1001, 16'h0201, 16'h0100, 16'h0102, 16'h6662);
        add(3'b000, 16'h0000, 16'h0000, 4'b1000, 16'h0201, 16'h0100, 16'h0102, 16'h6662);
        add(3'b010, 16'h0000, 16'h7773, 4'b0100, 16'h0201, 16'h0201, 16'h0203, 16'h7773);
        // imem_rdy with no request outstanding: single err pulse, nothing else changes.
        add(3'b010, 16'h0000, 16'hFFFF, 4'b0101, 16'h0201, 16'h0201, 16'h0203, 16'h7773);
        add(3'b000, 16'h0000, 16'h0000, 4'b0100, 16'h0201, 16'h0201, 16'h0203, 16'h7773);
        // PC wrap from 0xFFFE to 0x0000.
        add(3'b100, 16'hFFFE, 16'h0000, 4'b1000, 16'hFFFE, 16'h0201, 16'h0203, 16'h7773);
        add(3'b010, 16'h0000, 16'h1234, 4'b0100, 16'hFFFE, 16'hFFFE, 16'h0000, 16'h1234);
        add(3'b001, 16'h0000, 16'h0000, 4'b1000, 16'h0000, 16'hFFFE, 16'h0000, 16'h1234);
        add(3'b010, 16'h0000, I_NOP,    4'b0100, 16'h0000, 16'h0000, 16'h0002, I_NOP);
        // HALT fetched at 0x0010 and handed off.
        add(3'b100, 16'h0010, 16'h0000, 4'b1000, 16'h0010, 16'h0000, 16'h0002, I_NOP);
        add(3'b010, 16'h0000, 16'h0000, 4'b0100, 16'h0010, 16'h0010, 16'h0012, 16'h0000);
        add(3'b001, 16'h0000, 16'h0000, 4'b0010, 16'h0010, 16'h0010, 16'h0012, 16'h0000);

        repeat (2) @(posedge clk);
        #1;
        check_outs("reset", 4'b0000, 16'h0000, 16'h0000, 16'h0002, 16'h0000);
        rst_n = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            {redirect, imem_rdy, ifid_ready} = vq[i].ctl;
            redirect_pc = vq[i].rpc;
            imem_rdata  = vq[i].rdata;
            tick();
            check_outs($sformatf("row%0d", i), vq[i].flg, vq[i].addr, vq[i].ipc, vq[i].ipc2, vq[i].instr);
        end
        idle_inputs();

        for (int i = 0; i < 20; i++) begin
            tick();
            chk($sformatf("halt%0d imem_req", i), 16'(imem_req), 16'h0);
            chk($sformatf("halt%0d halted", i),   16'(halted),   16'h1);
        end

        redirect = 1'b1; redirect_pc = 16'h0020;
        tick();
        idle_inputs();
        check_outs("resume", 4'b1000, 16'h0020, 16'h0010, 16'h0012, 16'h0000);
        imem_rdy = 1'b1; imem_rdata = I_NOP;
        tick();
        idle_inputs();
        check_outs("resume_data", 4'b0100, 16'h0020, 16'h0020, 16'h0022, I_NOP);
        ifid_ready = 1'b1;
        tick();
        idle_inputs();
        check_outs("pending", 4'b1000, 16'h0022, 16'h0020, 16'h0022, I_NOP);

        #3;
        rst_n = 1'b0;
        #1;
        check_outs("async_rst", 4'b0000, 16'h0000, 16'h0000, 16'h0002, 16'h0000);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        check_outs("post_rst", 4'b1000, 16'h0000, 16'h0000, 16'h0002, 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
